in_peri_ctrl: RTL
=================

IN_PERI_CTRL -- requirements
Module: in_peri_ctrl

Interface
REQ-001 SHALL have parameter SW_W, default 32, switch channel count (1..32).
REQ-002 SHALL have parameter BTN_W, default 4, button channel count (1..31).
REQ-003 SHALL have parameter DEB_CYC, default 16, debounce stability cycles (>=2).
REQ-004 SHALL have parameter BASE_ADDR, default 32'h0000_7800, block base address (32-byte aligned).
REQ-005 SHALL have port i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port i_rst  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port i_lsu_wren  in  1  store strobe from LSU.
REQ-008 SHALL have port i_lsu_addr  in  32  LSU byte address.
REQ-009 SHALL have port i_st_data  in  32  store data.
REQ-010 SHALL have port i_num_byte  in  4  load size: 0001 byte, 0011 half, 1111 word.
REQ-011 SHALL have port i_sig_uns  in  1  1 = zero-extend, 0 = sign-extend.
REQ-012 SHALL have port i_io_sw  in  SW_W  raw asynchronous switch inputs.
REQ-013 SHALL have port i_io_btn  in  BTN_W  raw asynchronous button inputs.
REQ-014 SHALL have port o_ip_data  out  32  formatted load data.
REQ-015 SHALL have port o_irq  out  1  level interrupt request.

Function
REQ-016 SHALL decode a hit when i_lsu_addr[31:5] == BASE_ADDR[31:5]; word offset = i_lsu_addr[4:2].
REQ-017 SHALL implement the register map: 0 SW_VAL (RO), 1 BTN_VAL (RO), 2 BTN_PRESS (W1C), 3 SW_CHG (bit0, W1C), 4 IRQ_EN (RW: bits[BTN_W-1:0] per-button, bit31 switch); offsets 5..7 read 0, writes ignored.
REQ-018 SHALL pass every sw/btn bit through a 2-flop synchroniser before any other use.
REQ-019 SHALL debounce each channel with its own counter: increment while synced != stable, clear when equal; when counter == DEB_CYC-1 and synced != stable, stable <= synced and counter <= 0.
REQ-020 SHALL therefore reflect an input held constant in SW_VAL/BTN_VAL exactly 2+DEB_CYC edges after the first edge sampling the new level; glitches shorter than DEB_CYC synced cycles SHALL never reach stable.
REQ-021 SHALL zero-extend SW_VAL above SW_W and BTN_VAL/BTN_PRESS above BTN_W.
REQ-022 SHALL set BTN_PRESS[i] on the cycle stable button i goes 0->1; releases SHALL NOT set it.
REQ-023 SHALL set SW_CHG on any cycle where any stable switch bit changes.
REQ-024 SHALL clear W1C bits on a hit write with i_lsu_wren=1 for each 1 in i_st_data; a set event in the same cycle SHALL win (bit stays 1).
REQ-025 SHALL ignore writes when no hit, and writes to offsets 0, 1, 5..7.
REQ-026 SHALL register o_ip_data: value for the address presented at edge N appears after edge N (1-cycle latency); no hit -> 0.
REQ-027 SHALL format loads: 0001 selects byte addr[1:0], 0011 selects half addr[1], 1111 whole word; extend per i_sig_uns; any other i_num_byte -> 0 (never X).
REQ-028 SHALL drive o_irq registered: o_irq <= |(BTN_PRESS & IRQ_EN[BTN_W-1:0]) | (SW_CHG & IRQ_EN[31]).
REQ-029 SHALL perform no file I/O or simulation-only side effects.

Reset
REQ-030 SHALL, on i_rst=0, asynchronously clear synchronisers, stable values, counters, BTN_PRESS, SW_CHG, IRQ_EN, o_ip_data and o_irq to 0.
REQ-031 SHALL, on reset assertion mid-debounce, discard the partial count; after release the input debounces from zero with full 2+DEB_CYC latency.

Verification
REQ-032 SHALL cover: DEB_CYC=16, sw 0 -> 32'hA5A5_0F0F held -> SW_VAL reads 32'hA5A5_0F0F from edge 18 onward, 0 before; SW_CHG=1.
REQ-033 SHALL cover: btn[2] pulses 1 for 10 cycles (DEB_CYC=16) -> BTN_VAL and BTN_PRESS stay 0.
REQ-034 SHALL cover: btn[0] press held, IRQ_EN=1 -> BTN_PRESS=1, o_irq=1 one cycle later; write 1 to offset 2 -> BTN_PRESS=0, o_irq=0 next cycle.
REQ-035 SHALL cover: W1C clear coincident with new btn[1] rising edge -> BTN_PRESS[1] remains 1.
REQ-036 SHALL cover: SW_VAL=32'h0000_80FF, byte load addr offset 0, i_sig_uns=0 -> 32'hFFFF_FFFF; half load offset 0, i_sig_uns=0 -> 32'hFFFF_80FF; i_sig_uns=1 -> 32'h0000_80FF; i_num_byte=0100 -> 0.
REQ-037 SHALL cover: i_rst pulsed low during debounce and while o_irq=1 -> all outputs 0 immediately, IRQ_EN reads 0 after release.

Source files
------------

// File: rtl/in_peri_ctrl.sv
// -----------------------------------------------------------------------------
// in_peri_ctrl
// Memory-mapped input peripheral. It samples switches and buttons, debounces
// them, and tracks button presses and switch changes. It also raises a level
// interrupt and returns formatted load data to the LSU.
//
// Register map (word offsets from BASE_ADDR):
//   0 SW_VAL    RO   debounced switches, zero-extended
//   1 BTN_VAL   RO   debounced buttons, zero-extended
//   2 BTN_PRESS W1C  per-button rising-edge capture
//   3 SW_CHG    W1C  bit0: any debounced switch changed
//   4 IRQ_EN    RW   bits[BTN_W-1:0] per button, bit31 switch change
//   5..7             read 0, writes ignored
//
// Ports:
//   i_clk       sole clock, rising edge
//   i_rst       asynchronous active-low reset
//   i_lsu_wren  store strobe
//   i_lsu_addr  byte address
//   i_st_data   store data
//   i_num_byte  load size (0001 byte, 0011 half, 1111 word)
//   i_sig_uns   1 = zero-extend, 0 = sign-extend
//   i_io_sw     raw asynchronous switch inputs
//   i_io_btn    raw asynchronous button inputs
//   o_ip_data   registered load data (1-cycle latency, 0 when not addressed)
//   o_irq       registered level interrupt
// -----------------------------------------------------------------------------
module in_peri_ctrl #(
    parameter int          SW_W      = 32,
    parameter int          BTN_W     = 4,
    parameter int          DEB_CYC   = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_7800
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_lsu_wren,
    input  logic [31:0]      i_lsu_addr,
    input  logic [31:0]      i_st_data,
    input  logic [3:0]       i_num_byte,
    input  logic             i_sig_uns,
    input  logic [SW_W-1:0]  i_io_sw,
    input  logic [BTN_W-1:0] i_io_btn,
    output logic [31:0]      o_ip_data,
    output logic             o_irq
);

    localparam int CH_W  = SW_W + BTN_W;
    localparam int CNT_W = $clog2(DEB_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);
    // Only implemented IRQ_EN bits are writable.
    localparam logic [31:0] IRQ_EN_MASK =
        32'h8000_0000 | ((32'h0000_0001 << BTN_W) - 32'h0000_0001);

    localparam logic [2:0] OFF_SW_VAL    = 3'd0;
    localparam logic [2:0] OFF_BTN_VAL   = 3'd1;
    localparam logic [2:0] OFF_BTN_PRESS = 3'd2;
    localparam logic [2:0] OFF_SW_CHG    = 3'd3;
    localparam logic [2:0] OFF_IRQ_EN    = 3'd4;

    // Switches occupy the low channels, buttons the high ones.
    logic [CH_W-1:0]  raw_s;
    logic [CH_W-1:0]  sync1_r;
    logic [CH_W-1:0]  sync2_r;
    logic [CH_W-1:0]  stable_r;
    logic [CH_W-1:0]  stable_nxt_s;
    logic [CNT_W-1:0] cnt_r     [CH_W];
    logic [CNT_W-1:0] cnt_nxt_s [CH_W];

    logic [SW_W-1:0]  sw_stable_s;
    logic [SW_W-1:0]  sw_stable_nxt_s;
    logic [BTN_W-1:0] btn_stable_s;
    logic [BTN_W-1:0] btn_stable_nxt_s;
    logic [BTN_W-1:0] btn_rise_s;
    logic [BTN_W-1:0] btn_clr_s;
    logic [BTN_W-1:0] btn_press_r;
    logic             sw_chg_set_s;
    logic             sw_chg_clr_s;
    logic             sw_chg_r;
    logic [31:0]      irq_en_r;

    logic             hit_s;
    logic             wr_hit_s;
    logic [2:0]       off_s;
    logic [31:0]      word_s;
    logic [7:0]       byte_s;
    logic [15:0]      half_s;
    logic [31:0]      fmt_s;
    logic             irq_nxt_s;

    assign raw_s            = {i_io_btn, i_io_sw};
    assign sw_stable_s      = stable_r[SW_W-1:0];
    assign btn_stable_s     = stable_r[CH_W-1:SW_W];
    assign sw_stable_nxt_s  = stable_nxt_s[SW_W-1:0];
    assign btn_stable_nxt_s = stable_nxt_s[CH_W-1:SW_W];

    assign hit_s    = (i_lsu_addr[31:5] == BASE_ADDR[31:5]);
    assign off_s    = i_lsu_addr[4:2];
    assign wr_hit_s = hit_s & i_lsu_wren;

    // Events are taken from the debounced value about to be committed, so
    // the capture registers update on the same edge as the stable value.
    assign btn_rise_s   = btn_stable_nxt_s & ~btn_stable_s;
    assign sw_chg_set_s = (sw_stable_nxt_s != sw_stable_s);

    assign btn_clr_s    = (wr_hit_s && (off_s == OFF_BTN_PRESS)) ?
                          i_st_data[BTN_W-1:0] : {BTN_W{1'b0}};
    assign sw_chg_clr_s = wr_hit_s && (off_s == OFF_SW_CHG) && i_st_data[0];

    assign irq_nxt_s = (|(btn_press_r & irq_en_r[BTN_W-1:0])) |
                       (sw_chg_r & irq_en_r[31]);

    // Per-channel debounce: count while synced differs from stable, commit at the last count.
    always_comb begin
        stable_nxt_s = stable_r;
        for (int i = 0; i < CH_W; i++) begin
            cnt_nxt_s[i] = cnt_r[i];
            if (sync2_r[i] == stable_r[i]) begin
                cnt_nxt_s[i] = {CNT_W{1'b0}};
            end else if (cnt_r[i] == CNT_LAST) begin
                stable_nxt_s[i] = sync2_r[i];
                cnt_nxt_s[i]    = {CNT_W{1'b0}};
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
            end
        end
    end

    // Register read mux by word offset.
    always_comb begin
        case (off_s)
            OFF_SW_VAL:    word_s = 32'(sw_stable_s);
            OFF_BTN_VAL:   word_s = 32'(btn_stable_s);
            OFF_BTN_PRESS: word_s = 32'(btn_press_r);
            OFF_SW_CHG:    word_s = {31'd0, sw_chg_r};
            OFF_IRQ_EN:    word_s = irq_en_r;
            default:       word_s = 32'd0;
        endcase
    end

    // Load formatting: lane select plus sign/zero extension; unknown sizes give 0.
    always_comb begin
        case (i_lsu_addr[1:0])
            2'd1:    byte_s = word_s[15:8];
            2'd2:    byte_s = word_s[23:16];
            2'd3:    byte_s = word_s[31:24];
            default: byte_s = word_s[7:0];
        endcase
        if (i_lsu_addr[1]) begin
            half_s = word_s[31:16];
        end else begin
            half_s = word_s[15:0];
        end
        case (i_num_byte)
            4'b0001: fmt_s = i_sig_uns ? {24'd0, byte_s} : {{24{byte_s[7]}}, byte_s};
            4'b0011: fmt_s = i_sig_uns ? {16'd0, half_s} : {{16{half_s[15]}}, half_s};
            4'b1111: fmt_s = word_s;
            default: fmt_s = 32'd0;
        endcase
    end

    // Two-flop synchronisers, debounce counters and stable values.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sync1_r  <= {CH_W{1'b0}};
            sync2_r  <= {CH_W{1'b0}};
            stable_r <= {CH_W{1'b0}};
            for (int i = 0; i < CH_W; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            sync1_r  <= raw_s;
            sync2_r  <= sync1_r;
            stable_r <= stable_nxt_s;
            for (int i = 0; i < CH_W; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    // Sticky event flags (set wins over a coincident clear) and IRQ enable.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            btn_press_r <= {BTN_W{1'b0}};
            sw_chg_r    <= 1'b0;
            irq_en_r    <= 32'd0;
        end else begin
            btn_press_r <= (btn_press_r & ~btn_clr_s) | btn_rise_s;
            sw_chg_r    <= (sw_chg_r & ~sw_chg_clr_s) | sw_chg_set_s;
            if (wr_hit_s && (off_s == OFF_IRQ_EN)) begin
                irq_en_r <= i_st_data & IRQ_EN_MASK;
            end else begin
                irq_en_r <= irq_en_r;
            end
        end
    end

    // Registered load data and interrupt.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_ip_data <= 32'd0;
            o_irq     <= 1'b0;
        end else begin
            o_ip_data <= hit_s ? fmt_s : 32'd0;
            o_irq     <= irq_nxt_s;
        end
    end

endmodule
